// File: rtl/vmem_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vmem_port_ctrl
// Purpose  : Round-robin sequencer for the write/read port of the 4096x4
//            video cell memory. Optional rectangle fill engine: VMEM_FILL_EN.
// Revision : 1.0  initial release
// ============================================================================
module vmem_port_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic        req0_we,
    input  logic [11:0] req0_addr,
    input  logic [3:0]  req0_wdata,
    output logic        req0_ready,
    output logic        rsp0_valid,
    output logic [3:0]  rsp0_data,
    input  logic        req1_valid,
    input  logic        req1_we,
    input  logic [11:0] req1_addr,
    input  logic [3:0]  req1_wdata,
    output logic        req1_ready,
    output logic        rsp1_valid,
    output logic [3:0]  rsp1_data,
    input  logic        fill_start,
    input  logic [5:0]  fill_x0,
    input  logic [5:0]  fill_x1,
    input  logic [5:0]  fill_y0,
    input  logic [5:0]  fill_y1,
    input  logic [3:0]  fill_color,
    output logic        fill_busy,
    output logic        fill_done,
    output logic [11:0] mem_addr,
    output logic        mem_wr,
    output logic        mem_rd,
    output logic [3:0]  mem_wdata,
    input  logic [3:0]  mem_rdata
);

    localparam logic [1:0] SRC_REQ0 = 2'd0;
    localparam logic [1:0] SRC_REQ1 = 2'd1;
    localparam logic [1:0] SRC_FILL = 2'd2;

    function automatic logic [1:0] rr_next(input logic [1:0] src);
        return (src == SRC_FILL) ? SRC_REQ0 : src + 2'd1;
    endfunction

    logic [1:0]  rr_ptr;
    logic [1:0]  cand1;
    logic [1:0]  cand2;
    logic [1:0]  win;
    logic        grant_any;
    logic [3:0]  req_vec;
    logic [2:0]  grant;
    logic        fill_req;
    logic [11:0] fill_addr;
    logic [3:0]  fill_wdata;
    logic [11:0] sel_addr;
    logic [3:0]  sel_wdata;
    logic        sel_we;
    logic        rd_tag1;
    logic        rd_v2;
    logic        rd_tag2;

    // Requests are masked during reset so ready reads 0 while rst_n is low.
    always_comb begin
        req_vec   = {1'b0, fill_req, req1_valid, req0_valid} & {4{rst_n}};
        cand1     = rr_next(rr_ptr);
        cand2     = rr_next(cand1);
        grant_any = 1'b1;
        win       = rr_ptr;
        if (req_vec[rr_ptr])     win = rr_ptr;
        else if (req_vec[cand1]) win = cand1;
        else if (req_vec[cand2]) win = cand2;
        else                     grant_any = 1'b0;
    end

    assign grant      = grant_any ? (3'b001 << win) : 3'b000;
    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    always_comb begin
        sel_addr  = fill_addr;
        sel_wdata = fill_wdata;
        sel_we    = 1'b1;
        case (win)
            SRC_REQ0: begin
                sel_addr  = req0_addr;
                sel_wdata = req0_wdata;
                sel_we    = req0_we;
            end
            SRC_REQ1: begin
                sel_addr  = req1_addr;
                sel_wdata = req1_wdata;
                sel_we    = req1_we;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= SRC_REQ0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wr    <= 1'b0;
            mem_rd    <= 1'b0;
            rd_tag1   <= 1'b0;
        end else if (grant_any) begin
            rr_ptr    <= rr_next(win);
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_wr    <= sel_we;
            mem_rd    <= ~sel_we;
            if (!sel_we) rd_tag1 <= win[0];
        end else begin
            mem_wr    <= 1'b0;
            mem_rd    <= 1'b0;
        end
    end

    // mem_rd is the first tag stage; DOB is valid one cycle after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_v2      <= 1'b0;
            rd_tag2    <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp1_data  <= '0;
        end else begin
            rd_v2      <= mem_rd;
            rd_tag2    <= rd_tag1;
            rsp0_valid <= rd_v2 & ~rd_tag2;
            rsp1_valid <= rd_v2 &  rd_tag2;
            if (rd_v2 && !rd_tag2) rsp0_data <= mem_rdata;
            if (rd_v2 &&  rd_tag2) rsp1_data <= mem_rdata;
        end
    end

`ifdef VMEM_FILL_EN
    localparam logic [1:0] F_IDLE  = 2'd0;
    localparam logic [1:0] F_RUN   = 2'd1;
    localparam logic [1:0] F_EMPTY = 2'd2;
    localparam logic [1:0] F_DONE  = 2'd3;

    logic [1:0] fill_state;
    logic [1:0] fill_state_nxt;
    logic [5:0] cur_x;
    logic [5:0] cur_y;
    logic [5:0] lim_x0;
    logic [5:0] lim_x1;
    logic [5:0] lim_y1;
    logic [3:0] color_q;
    logic       fill_grant;
    logic       fill_accept;
    logic       rect_empty;
    logic       last_cell;

    assign fill_grant  = grant[2];
    assign fill_accept = fill_start & ((fill_state == F_IDLE) | (fill_state == F_DONE));
    assign rect_empty  = (fill_x0 > fill_x1) | (fill_y0 > fill_y1);
    assign last_cell   = (cur_x == lim_x1) & (cur_y == lim_y1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fill_state <= F_IDLE;
        else        fill_state <= fill_state_nxt;
    end

    always_comb begin
        fill_state_nxt = fill_state;
        case (fill_state)
            F_IDLE, F_DONE: begin
                if (fill_accept) fill_state_nxt = rect_empty ? F_EMPTY : F_RUN;
                else             fill_state_nxt = F_IDLE;
            end
            F_RUN:   if (fill_grant && last_cell) fill_state_nxt = F_DONE;
            F_EMPTY: fill_state_nxt = F_DONE;
            default: fill_state_nxt = F_IDLE;
        endcase
    end

    always_comb begin
        fill_req  = (fill_state == F_RUN);
        fill_busy = (fill_state == F_RUN) | (fill_state == F_EMPTY);
        fill_done = (fill_state == F_DONE);
    end

    // Row-major cursor: column wraps back to x0 and bumps the row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_x   <= '0;
            cur_y   <= '0;
            lim_x0  <= '0;
            lim_x1  <= '0;
            lim_y1  <= '0;
            color_q <= '0;
        end else if (fill_accept) begin
            cur_x   <= fill_x0;
            cur_y   <= fill_y0;
            lim_x0  <= fill_x0;
            lim_x1  <= fill_x1;
            lim_y1  <= fill_y1;
            color_q <= fill_color;
        end else if (fill_grant && !last_cell) begin
            if (cur_x == lim_x1) begin
                cur_x <= lim_x0;
                cur_y <= cur_y + 6'd1;
            end else begin
                cur_x <= cur_x + 6'd1;
            end
        end
    end

    assign fill_addr  = {cur_y, cur_x};
    assign fill_wdata = color_q;
`else
    logic unused_fill;

    assign fill_req    = 1'b0;
    assign fill_addr   = '0;
    assign fill_wdata  = '0;
    assign fill_busy   = 1'b0;
    assign fill_done   = 1'b0;
    assign unused_fill = ^{fill_start, fill_x0, fill_x1, fill_y0, fill_y1, fill_color, grant[2]};
`endif

endmodule
`default_nettype wire

// File: tb/tb_vmem_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vmem_port_ctrl
// Purpose  : Scoreboard bench for vmem_port_ctrl with a behavioural RAM.
// Revision : 1.0  initial release
// ============================================================================
module tb_vmem_port_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_we, req0_ready, rsp0_valid;
    logic [11:0] req0_addr;
    logic [3:0]  req0_wdata, rsp0_data;
    logic        req1_valid, req1_we, req1_ready, rsp1_valid;
    logic [11:0] req1_addr;
    logic [3:0]  req1_wdata, rsp1_data;
    logic        fill_start, fill_busy, fill_done;
    logic [5:0]  fill_x0, fill_x1, fill_y0, fill_y1;
    logic [3:0]  fill_color;
    logic [11:0] mem_addr;
    logic        mem_wr, mem_rd;
    logic [3:0]  mem_wdata, mem_rdata;

    vmem_port_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
        .fill_start(fill_start), .fill_x0(fill_x0), .fill_x1(fill_x1),
        .fill_y0(fill_y0), .fill_y1(fill_y1), .fill_color(fill_color),
        .fill_busy(fill_busy), .fill_done(fill_done),
        .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_rd(mem_rd),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       tag;
        logic [3:0] data;
        int         cyc;
    } rsp_t;

    rsp_t        sb[$];
    int          grant_log[$];
    logic [3:0]  ram     [4096];
    logic [3:0]  ref_mem [4096];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic        mem_chk = 1'b1;
    logic        addr_known = 1'b1;
    logic        exp_wr = 1'b0, exp_rd = 1'b0;
    logic [11:0] exp_addr = '0;
    logic [3:0]  exp_wdata = '0;
    logic        hs0_seen = 1'b0, hs1_seen = 1'b0;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Synchronous single-port RAM standing in for port B.
    initial begin
        forever begin
            @(posedge clk);
            if (mem_wr) ram[mem_addr] <= mem_wdata;
            if (mem_rd) mem_rdata <= ram[mem_addr];
        end
    end

    task automatic note_grant(input int p, input logic we, input logic [11:0] a, input logic [3:0] d);
        rsp_t e;
        exp_wr     = we;
        exp_rd     = ~we;
        exp_addr   = a;
        exp_wdata  = d;
        addr_known = 1'b1;
        if (we) begin
            ref_mem[a] = d;
        end else begin
            e.tag  = (p == 1);
            e.data = ref_mem[a];
            e.cyc  = cyc + 3;
            sb.push_back(e);
        end
        grant_log.push_back(p);
    endtask

    // Monitor: checks the memory bus and responses, then records this cycle's handshakes.
    initial begin
        logic ev0, ev1, hs0, hs1;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                sb.delete();
                exp_wr = 0; exp_rd = 0; exp_addr = '0; exp_wdata = '0;
                addr_known = 1'b1; hs0_seen = 0; hs1_seen = 0;
            end else begin
                while (sb.size() > 0 && sb[0].cyc < cyc) begin
                    chk_eq("rsp_cycle", cyc, sb[0].cyc);
                    void'(sb.pop_front());
                end
                ev0 = (sb.size() > 0) && (sb[0].cyc == cyc) && !sb[0].tag;
                ev1 = (sb.size() > 0) && (sb[0].cyc == cyc) &&  sb[0].tag;
                chk_eq("rsp0_valid", rsp0_valid, ev0);
                chk_eq("rsp1_valid", rsp1_valid, ev1);
                if (ev0) chk_eq("rsp0_data", rsp0_data, sb[0].data);
                if (ev1) chk_eq("rsp1_data", rsp1_data, sb[0].data);
                if (ev0 || ev1) void'(sb.pop_front());
                if (mem_chk) begin
                    chk_eq("mem_wr", mem_wr, exp_wr);
                    chk_eq("mem_rd", mem_rd, exp_rd);
                    if (addr_known) chk_eq("mem_addr", mem_addr, exp_addr);
                    if (exp_wr)     chk_eq("mem_wdata", mem_wdata, exp_wdata);
                end else begin
                    addr_known = 1'b0;
                end
                exp_wr = 0;
                exp_rd = 0;
                hs0 = req0_valid && req0_ready;
                hs1 = req1_valid && req1_ready;
                if (hs0) note_grant(0, req0_we, req0_addr, req0_wdata);
                if (hs1) note_grant(1, req1_we, req1_addr, req1_wdata);
                hs0_seen = hs0;
                hs1_seen = hs1;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic issue(input int p, input logic we, input logic [11:0] a, input logic [3:0] d);
        logic done;
        if (p == 0) begin
            req0_valid = 1'b1; req0_we = we; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = 1'b1; req1_we = we; req1_addr = a; req1_wdata = d;
        end
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(posedge clk);
            done = (p == 0) ? hs0_seen : hs1_seen;
        end
        chk_eq("hs_timeout", done, 1);
        #1;
    endtask

    task automatic idle(input int p);
        if (p == 0) req0_valid = 1'b0;
        else        req1_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

`ifdef VMEM_FILL_EN
    task automatic pulse_fill(input logic [5:0] x0, input logic [5:0] x1,
                              input logic [5:0] y0, input logic [5:0] y1, input logic [3:0] c);
        fill_x0 = x0; fill_x1 = x1; fill_y0 = y0; fill_y1 = y1; fill_color = c;
        fill_start = 1'b1;
        @(posedge clk);
        #1;
        fill_start = 1'b0;
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 12'h0C3; req0_wdata = 4'h5;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 12'h0C3; req1_wdata = 4'h0;
        fill_start = 1'b0; fill_x0 = '0; fill_x1 = '0; fill_y0 = '0; fill_y1 = '0; fill_color = '0;
        wait_cycles(3);
        chk_eq("rst_req0_ready", req0_ready, 0);
        chk_eq("rst_req1_ready", req1_ready, 0);
        chk_eq("rst_mem_bus", {mem_addr, mem_wr, mem_rd, mem_wdata}, 0);
        chk_eq("rst_rsp", {rsp0_valid, rsp0_data, rsp1_valid, rsp1_data}, 0);
        chk_eq("rst_fill", {fill_busy, fill_done}, 0);

        // First grant after reset must go to req0 even with req1 also waiting.
        rst_n = 1'b1;
        fork
            begin issue(0, 1'b1, 12'h0C3, 4'h5); idle(0); end
            begin issue(1, 1'b0, 12'h0C3, 4'h0); idle(1); end
        join
        chk_eq("first_grant", grant_log[0], 0);
        chk_eq("second_grant", grant_log[1], 1);
        wait_cycles(4);

        issue(0, 1'b0, 12'h0C3, 4'h0); idle(0);
        wait_cycles(4);

        for (int i = 0; i < 6; i++) begin
            issue(i % 2, 1'b1, 12'h300 + 12'(i), 4'(i + 1));
            idle(i % 2);
        end

        grant_log.delete();
        fork
            begin
                for (int i = 0; i < 6; i += 2) issue(0, 1'b0, 12'h300 + 12'(i), 4'h0);
                idle(0);
            end
            begin
                for (int i = 1; i < 6; i += 2) issue(1, 1'b0, 12'h300 + 12'(i), 4'h0);
                idle(1);
            end
        join
        chk_eq("alt_len", grant_log.size(), 6);
        for (int k = 0; k + 1 < grant_log.size(); k++)
            chk_eq("alt_grant", grant_log[k + 1], 1 - grant_log[k]);
        wait_cycles(5);

`ifdef VMEM_FILL_EN
        begin
            logic [11:0] exp_fill [6] = '{12'h042, 12'h043, 12'h044, 12'h082, 12'h083, 12'h084};
            int wr_idx[$];
            logic [11:0] wr_addr[$];
            logic [3:0]  wr_dat[$];
            int done_idx, done_cnt, srcs[$], first;
            logic busy0, busy_at_done;
            mem_chk = 1'b0;

            pulse_fill(6'd2, 6'd4, 6'd1, 6'd2, 4'hA);
            fill_x1 = 6'd9;
            done_cnt = 0; done_idx = -1; busy0 = 1'b0; busy_at_done = 1'b1;
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                if (k == 0) busy0 = fill_busy;
                if (mem_wr) begin
                    wr_idx.push_back(k); wr_addr.push_back(mem_addr); wr_dat.push_back(mem_wdata);
                end
                if (fill_done) begin done_cnt++; done_idx = k; busy_at_done = fill_busy; end
                if (k == 2) begin
                    fill_x0 = 0; fill_x1 = 0; fill_y0 = 0; fill_y1 = 0; fill_start = 1'b1;
                end
                if (k == 3) fill_start = 1'b0;
            end
            chk_eq("fill_busy_start", busy0, 1);
            chk_eq("fill_nwr", wr_idx.size(), 6);
            for (int k = 0; k < wr_idx.size() && k < 6; k++) begin
                chk_eq("fill_addr", wr_addr[k], exp_fill[k]);
                chk_eq("fill_data", wr_dat[k], 4'hA);
                chk_eq("fill_cycle", wr_idx[k], k + 1);
            end
            chk_eq("fill_done_cnt", done_cnt, 1);
            chk_eq("fill_done_idx", done_idx, 6);
            chk_eq("fill_busy_drop", busy_at_done, 0);
            wait_cycles(2);

            @(posedge clk); #1;
            pulse_fill(6'd5, 6'd3, 6'd0, 6'd0, 4'h3);
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                chk_eq("empty_busy", fill_busy, (k == 0));
                chk_eq("empty_done", fill_done, (k == 1));
                chk_eq("empty_nowr", mem_wr, 0);
            end
            wait_cycles(2);

            fork
                begin
                    for (int i = 0; i < 10; i++) issue(0, 1'b1, 12'h400 + 12'(i), 4'h1);
                    idle(0);
                end
                begin
                    for (int i = 0; i < 10; i++) issue(1, 1'b1, 12'h800 + 12'(i), 4'h2);
                    idle(1);
                end
                begin
                    wait_cycles(2);
                    pulse_fill(6'd0, 6'd3, 6'd0, 6'd0, 4'h7);
                    for (int k = 0; k < 16; k++) begin
                        @(negedge clk);
                        if (mem_wr) srcs.push_back(mem_addr[11:10] == 2'b01 ? 0 :
                                                   mem_addr[11:10] == 2'b10 ? 1 : 2);
                    end
                end
            join
            first = -1;
            for (int k = 0; k < srcs.size(); k++) if (first < 0 && srcs[k] == 2) first = k;
            chk_eq("rr3_len", (first >= 0) && (srcs.size() >= first + 6), 1);
            for (int k = first; first >= 0 && k < first + 5 && k + 1 < srcs.size(); k++)
                chk_eq("rr3_order", srcs[k + 1], (srcs[k] + 1) % 3);
            wait_cycles(12);

            pulse_fill(6'd0, 6'd15, 6'd5, 6'd5, 4'hC);
            first = 0;
            for (int k = 0; k < 20 && first < 3; k++) begin
                @(negedge clk);
                if (mem_wr) first++;
            end
            chk_eq("fill_progress", first, 3);
            @(posedge clk); #1;
        end
`endif

        // Reset with a read in flight (and a fill running when present).
        issue(0, 1'b0, 12'h301, 4'h0);
        #1;
        rst_n = 1'b0;
        #1;
        chk_eq("arst_req0_ready", req0_ready, 0);
        chk_eq("arst_mem_bus", {mem_addr, mem_wr, mem_rd, mem_wdata}, 0);
        chk_eq("arst_rsp", {rsp0_valid, rsp0_data, rsp1_valid, rsp1_data}, 0);
        chk_eq("arst_fill", {fill_busy, fill_done}, 0);
        idle(0);
        mem_chk = 1'b1;
        wait_cycles(2);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk_eq("post_rst_busy", fill_busy, 0);
        end
        wait_cycles(2);
        chk_eq("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
